// File: rtl/reset_sequencer.sv
// Releases N_DOM reset domains in index order after a hold time and clock lock.
// Define RSTSEQ_LOCK_WDOG_EN to enable the sticky lock-timeout watchdog on o_err.
module reset_sequencer #(
  parameter int N_DOM        = 4,
  parameter int HOLD_CYC     = 16,
  parameter int GAP_CYC      = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_locked,
  input  logic                         i_sw_rst,
  output logic [N_DOM-1:0]             o_rst,
  output logic                         o_done,
  output logic [$clog2(N_DOM+1)-1:0]   o_stage,
  output logic                         o_err
);

  localparam int SW = $clog2(N_DOM + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  generate
    if (N_DOM < 1 || HOLD_CYC < 1 || GAP_CYC < 1 || LOCK_TIMEOUT < 1) begin : g_bad_param
      $error("reset_sequencer: N_DOM, HOLD_CYC, GAP_CYC and LOCK_TIMEOUT must all be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_RELEASE,
    ST_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [HW-1:0]     r_hold_cnt, w_hold_nxt;
  logic [GW-1:0]     r_gap_cnt, w_gap_nxt;
  logic [SW-1:0]     r_stage, w_stage_nxt;
  logic [N_DOM-1:0]  r_rst, w_rst_nxt;
  logic              r_done, w_done_nxt;
  logic              w_abort;

  // Lock loss only matters once the sequence has started releasing domains.
  assign w_abort = i_sw_rst | (~i_locked & (r_state == ST_RELEASE || r_state == ST_DONE));

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_stage_nxt = r_stage;
    w_rst_nxt   = r_rst;
    w_done_nxt  = r_done;
    if (w_abort) begin
      w_state_nxt = ST_HOLD;
      w_hold_nxt  = '0;
      w_gap_nxt   = '0;
      w_stage_nxt = '0;
      w_rst_nxt   = '1;
      w_done_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_hold_cnt == HW'(HOLD_CYC - 1)) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold_cnt + HW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (i_locked) begin
            w_state_nxt = ST_RELEASE;
            w_gap_nxt   = '0;
            w_stage_nxt = '0;
          end
        end
        ST_RELEASE: begin
          if (r_gap_cnt == GW'(GAP_CYC - 1)) begin
            w_gap_nxt   = '0;
            w_stage_nxt = r_stage + SW'(1);
            for (int i = 0; i < N_DOM; i++) begin
              if (i == int'(r_stage)) w_rst_nxt[i] = 1'b0;
            end
            if (r_stage == SW'(N_DOM - 1)) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_gap_nxt = r_gap_cnt + GW'(1);
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_stage    <= '0;
      r_rst      <= '1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_stage    <= w_stage_nxt;
      r_rst      <= w_rst_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign o_rst   = r_rst;
  assign o_done  = r_done;
  assign o_stage = r_stage;

`ifdef RSTSEQ_LOCK_WDOG_EN
  localparam int WW = $clog2(LOCK_TIMEOUT + 1);

  logic [WW-1:0] r_wdog_cnt;
  logic          r_err;

  // The watchdog only flags; the sequence keeps waiting for a late lock.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wdog_cnt <= '0;
      r_err      <= 1'b0;
    end else if (r_state == ST_WAIT_LOCK) begin
      if (r_wdog_cnt == WW'(LOCK_TIMEOUT - 1)) r_err <= 1'b1;
      if (w_state_nxt != ST_WAIT_LOCK) begin
        r_wdog_cnt <= '0;
      end else if (r_wdog_cnt != WW'(LOCK_TIMEOUT - 1)) begin
        r_wdog_cnt <= r_wdog_cnt + WW'(1);
      end
    end else begin
      r_wdog_cnt <= '0;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus randomized
// lock/abort traffic compared against an edge-timestamp reference model.
module tb_reset_sequencer;

  localparam int N    = 4;
  localparam int HOLD = 16;
  localparam int GAP  = 8;
  localparam int LT   = 64;
  localparam int SW   = $clog2(N + 1);
`ifdef RSTSEQ_LOCK_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic          clk;
  logic          i_rst;
  logic          i_locked;
  logic          i_sw_rst;
  logic [N-1:0]  o_rst;
  logic          o_done;
  logic [SW-1:0] o_stage;
  logic          o_err;

  reset_sequencer #(
    .N_DOM(N), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_locked(i_locked), .i_sw_rst(i_sw_rst),
    .o_rst(o_rst), .o_done(o_done), .o_stage(o_stage), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: absolute edge of last restart and of lock acceptance (-1 = not yet).
  int edge_n    = 0;
  int t_restart = 0;
  int t_lock    = -1;
  bit m_err     = 1'b0;

  function automatic void model_edge(input bit rst, input bit sw, input bit lk);
    bit waiting;
    if (rst) begin
      t_restart = edge_n;
      t_lock    = -1;
      m_err     = 1'b0;
    end else begin
      waiting = (t_lock < 0) && (edge_n > t_restart + HOLD);
      if (WDOG && waiting && (edge_n >= t_restart + HOLD + LT)) m_err = 1'b1;
      if (sw || (!lk && t_lock >= 0)) begin
        t_restart = edge_n;
        t_lock    = -1;
      end else if (waiting && lk) begin
        t_lock = edge_n;
      end
    end
  endfunction

  function automatic void exp_outs(output logic [N-1:0] er, output logic ed,
                                   output logic [SW-1:0] es, output logic ee);
    int rel;
    rel = (t_lock < 0) ? 0 : (edge_n - t_lock) / GAP;
    if (rel > N) rel = N;
    er = '1;
    for (int k = 0; k < N; k++) if (k < rel) er[k] = 1'b0;
    ed = (rel == N);
    es = SW'(rel);
    ee = m_err;
  endfunction

  task automatic tick(input bit rst, input bit sw, input bit lk);
    i_rst = rst; i_sw_rst = sw; i_locked = lk;
    @(posedge clk);
    edge_n++;
    model_edge(rst, sw, lk);
    #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] er; logic ed; logic [SW-1:0] es; logic ee;
    for (int r = 0; r < 3; r++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_total++;
      if (o_rst !== 4'b1111 || o_done !== 1'b0 || o_stage !== 3'd0 || o_err !== 1'b0)
        $display("FAIL reset_state: got rst=%b done=%b stage=%0d err=%b, want rst=1111 done=0 stage=0 err=0",
                 o_rst, o_done, o_stage, o_err);
      else n_pass++;
    end
    exp_outs(er, ed, es, ee);
    n_total++;
    if (o_rst !== er || o_done !== ed || o_stage !== es || o_err !== ee)
      $display("FAIL reset_model: got rst=%b done=%b stage=%0d err=%b, want rst=%b done=%b stage=%0d err=%b",
               o_rst, o_done, o_stage, o_err, er, ed, es, ee);
    else n_pass++;
  endtask

  task automatic test_nominal();
    logic [N-1:0] er; logic ed; logic [SW-1:0] es; logic ee;
    logic [N-1:0] want; bit chk;
    tick(1'b1, 1'b0, 1'b1);
    for (int e = 1; e <= 60; e++) begin
      tick(1'b0, 1'b0, 1'b1);
      exp_outs(er, ed, es, ee);
      n_total++;
      if (o_rst !== er || o_done !== ed || o_stage !== es || o_err !== ee)
        $display("FAIL nominal edge %0d: got rst=%b done=%b stage=%0d err=%b, want rst=%b done=%b stage=%0d err=%b",
                 e, o_rst, o_done, o_stage, o_err, er, ed, es, ee);
      else n_pass++;
      chk = 1'b1; want = '1;
      case (e)
        24: want = 4'b1111;
        25: want = 4'b1110;
        33: want = 4'b1100;
        41: want = 4'b1000;
        49: want = 4'b0000;
        default: chk = 1'b0;
      endcase
      if (chk) begin
        n_total++;
        if (o_rst !== want) $display("FAIL nominal_release edge %0d: got rst=%b, want %b", e, o_rst, want);
        else n_pass++;
      end
      if (e == 48 || e == 49) begin
        n_total++;
        if (o_done !== (e == 49) || o_stage !== ((e == 49) ? 3'd4 : 3'd3))
          $display("FAIL nominal_done edge %0d: got done=%b stage=%0d", e, o_done, o_stage);
        else n_pass++;
      end
    end
  endtask

  task automatic test_late_lock();
    logic [N-1:0] er; logic ed; logic [SW-1:0] es; logic ee;
    tick(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 135; e++) begin
      tick(1'b0, 1'b0, e >= 100);
      exp_outs(er, ed, es, ee);
      n_total++;
      if (o_rst !== er || o_done !== ed || o_stage !== es || o_err !== ee)
        $display("FAIL late_lock edge %0d: got rst=%b done=%b stage=%0d err=%b, want rst=%b done=%b stage=%0d err=%b",
                 e, o_rst, o_done, o_stage, o_err, er, ed, es, ee);
      else n_pass++;
      if (e == 107 || e == 108) begin
        n_total++;
        if (o_rst !== ((e == 107) ? 4'b1111 : 4'b1110))
          $display("FAIL late_lock_rel0 edge %0d: got rst=%b", e, o_rst);
        else n_pass++;
      end
      if (e == 131 || e == 132) begin
        n_total++;
        if (o_done !== (e == 132)) $display("FAIL late_lock_done edge %0d: got done=%b", e, o_done);
        else n_pass++;
      end
`ifdef RSTSEQ_LOCK_WDOG_EN
      if (e == 79 || e == 80 || e == 135) begin
        n_total++;
        if (o_err !== (e != 79)) $display("FAIL wdog_err edge %0d: got err=%b, want %b", e, o_err, e != 79);
        else n_pass++;
      end
`endif
    end
  endtask

  task automatic test_sw_pulse();
    logic [N-1:0] er; logic ed; logic [SW-1:0] es; logic ee;
    tick(1'b1, 1'b0, 1'b1);
    for (int e = 1; e <= 62; e++) begin
      tick(1'b0, e == 35, 1'b1);
      exp_outs(er, ed, es, ee);
      n_total++;
      if (o_rst !== er || o_done !== ed || o_stage !== es || o_err !== ee)
        $display("FAIL sw_pulse edge %0d: got rst=%b done=%b stage=%0d err=%b, want rst=%b done=%b stage=%0d err=%b",
                 e, o_rst, o_done, o_stage, o_err, er, ed, es, ee);
      else n_pass++;
      if (e == 34 || e == 35 || e == 59 || e == 60) begin
        n_total++;
        if (o_rst !== ((e == 34) ? 4'b1100 : (e == 60) ? 4'b1110 : 4'b1111) ||
            o_stage !== ((e == 34) ? 3'd2 : (e == 60) ? 3'd1 : 3'd0))
          $display("FAIL sw_pulse_restart edge %0d: got rst=%b stage=%0d", e, o_rst, o_stage);
        else n_pass++;
      end
    end
  endtask

  task automatic test_abort_on_release();
    logic [N-1:0] er; logic ed; logic [SW-1:0] es; logic ee;
    tick(1'b1, 1'b0, 1'b1);
    for (int e = 1; e <= 40; e++) begin
      tick(1'b0, e == 33, 1'b1);
      exp_outs(er, ed, es, ee);
      n_total++;
      if (o_rst !== er || o_done !== ed || o_stage !== es || o_err !== ee)
        $display("FAIL abort_release edge %0d: got rst=%b done=%b stage=%0d err=%b, want rst=%b done=%b stage=%0d err=%b",
                 e, o_rst, o_done, o_stage, o_err, er, ed, es, ee);
      else n_pass++;
      if (e == 32 || e == 33) begin
        n_total++;
        if (o_rst !== ((e == 32) ? 4'b1110 : 4'b1111))
          $display("FAIL abort_release_bits edge %0d: got rst=%b", e, o_rst);
        else n_pass++;
      end
    end
  endtask

  task automatic test_lock_drop_done();
    logic [N-1:0] er; logic ed; logic [SW-1:0] es; logic ee;
    tick(1'b1, 1'b0, 1'b1);
    for (int e = 1; e <= 90; e++) begin
      tick(1'b0, 1'b0, e != 60);
      exp_outs(er, ed, es, ee);
      n_total++;
      if (o_rst !== er || o_done !== ed || o_stage !== es || o_err !== ee)
        $display("FAIL lock_drop edge %0d: got rst=%b done=%b stage=%0d err=%b, want rst=%b done=%b stage=%0d err=%b",
                 e, o_rst, o_done, o_stage, o_err, er, ed, es, ee);
      else n_pass++;
      if (e == 59 || e == 60 || e == 85) begin
        n_total++;
        if (o_rst !== ((e == 59) ? 4'b0000 : (e == 60) ? 4'b1111 : 4'b1110) || o_done !== (e == 59))
          $display("FAIL lock_drop_restart edge %0d: got rst=%b done=%b", e, o_rst, o_done);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] er; logic ed; logic [SW-1:0] es; logic ee;
    bit lk, sw, rst;
    int sw_hold;
    lk = 1'b1; sw_hold = 0;
    tick(1'b1, 1'b0, lk);
    for (int e = 1; e <= 4000; e++) begin
      if ($urandom_range(0, 79) == 0) lk = ~lk;
      if (sw_hold == 0 && $urandom_range(0, 199) == 0) sw_hold = $urandom_range(1, 20);
      sw = (sw_hold > 0);
      if (sw_hold > 0) sw_hold--;
      rst = ($urandom_range(0, 499) == 0);
      tick(rst, sw, lk);
      exp_outs(er, ed, es, ee);
      n_total++;
      if (o_rst !== er || o_done !== ed || o_stage !== es || o_err !== ee)
        $display("FAIL random edge %0d: got rst=%b done=%b stage=%0d err=%b, want rst=%b done=%b stage=%0d err=%b",
                 e, o_rst, o_done, o_stage, o_err, er, ed, es, ee);
      else n_pass++;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_sw_rst = 1'b0; i_locked = 1'b0;
    test_reset();
    test_nominal();
    test_late_lock();
    test_reset();
    test_sw_pulse();
    test_abort_on_release();
    test_lock_drop_done();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
